// File: rtl/watch_key_ctrl_if.sv
// Keypad/tick bus between the watch key controller and its surroundings.
// master drives mode, tick and row lines; slave is the controller.
interface watch_key_ctrl_if;
  logic       set;
  logic       tick_1hz;
  logic       key_row2;
  logic       key_row3;
  logic       key_row4;
  logic       key_col1;
  logic       key_col2;
  logic [5:0] inc_pulse;
  logic       tick_out;
  logic       busy;

  modport master (
    output set, tick_1hz, key_row2, key_row3, key_row4,
    input  key_col1, key_col2, inc_pulse, tick_out, busy
  );

  modport slave (
    input  set, tick_1hz, key_row2, key_row3, key_row4,
    output key_col1, key_col2, inc_pulse, tick_out, busy
  );
endinterface

// File: rtl/watch_key_ctrl.sv
// Two-column keypad scanner with debounce; turns each press into one digit
// increment pulse and gates the 1 Hz tick while in set mode.
module watch_key_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd33000,
  parameter logic [3:0]  SETTLE_CYCLES   = 4'd2
) (
  input logic            clk,
  input logic            reset,
  watch_key_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PROBE1   = 3'd1,
    PROBE2   = 3'd2,
    DEBOUNCE = 3'd3,
    HOLD     = 3'd4
  } state_t;

  state_t      state;
  logic [3:0]  settle_cnt;
  logic [15:0] db_cnt;
  logic [1:0]  row_sel;   // 2 = row2, 1 = row3, 0 = row4
  logic        col_sel;   // 1 = col1, 0 = col2
  logic        armed;

  logic [2:0]  rows;
  logic        any_low;
  logic [1:0]  pri_row;
  logic        row_low;
  logic        settle_done;
  logic        db_done;
  logic [5:0]  key_onehot;

  assign rows        = {bus.key_row2, bus.key_row3, bus.key_row4};
  assign any_low     = rows != 3'b111;
  assign row_low     = ~rows[row_sel];
  assign settle_done = settle_cnt == SETTLE_CYCLES - 4'd1;
  assign db_done     = db_cnt == DEBOUNCE_CYCLES - 16'd1;
  assign key_onehot  = 6'b000001 << {row_sel, col_sel};

  always_comb begin
    pri_row = 2'd0;
    if (!rows[2])      pri_row = 2'd2;
    else if (!rows[1]) pri_row = 2'd1;
  end

  // armed blocks a key still held across reset until it has been released
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      settle_cnt    <= '0;
      db_cnt        <= '0;
      row_sel       <= '0;
      col_sel       <= 1'b0;
      armed         <= 1'b0;
      bus.key_col1  <= 1'b0;
      bus.key_col2  <= 1'b0;
      bus.inc_pulse <= '0;
      bus.tick_out  <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.tick_out  <= bus.tick_1hz & ~bus.set;
      bus.inc_pulse <= '0;
      case (state)
        IDLE: begin
          if (!any_low) begin
            armed <= 1'b1;
          end else if (armed) begin
            state        <= PROBE1;
            settle_cnt   <= '0;
            bus.key_col1 <= 1'b0;
            bus.key_col2 <= 1'b1;
            bus.busy     <= 1'b1;
          end
        end
        PROBE1: begin
          if (!settle_done) begin
            settle_cnt <= settle_cnt + 4'd1;
          end else if (any_low) begin
            state   <= DEBOUNCE;
            col_sel <= 1'b1;
            row_sel <= pri_row;
            db_cnt  <= '0;
          end else begin
            state        <= PROBE2;
            settle_cnt   <= '0;
            bus.key_col1 <= 1'b1;
            bus.key_col2 <= 1'b0;
          end
        end
        PROBE2: begin
          if (!settle_done) begin
            settle_cnt <= settle_cnt + 4'd1;
          end else if (any_low) begin
            state   <= DEBOUNCE;
            col_sel <= 1'b0;
            row_sel <= pri_row;
            db_cnt  <= '0;
          end else begin
            state        <= IDLE;
            bus.key_col1 <= 1'b0;
            bus.key_col2 <= 1'b0;
            bus.busy     <= 1'b0;
          end
        end
        DEBOUNCE: begin
          if (!row_low) begin
            state        <= IDLE;
            bus.key_col1 <= 1'b0;
            bus.key_col2 <= 1'b0;
            bus.busy     <= 1'b0;
          end else if (db_done) begin
            state  <= HOLD;
            db_cnt <= '0;
            // same set sample as tick_out, so the two never coincide
            if (bus.set) bus.inc_pulse <= key_onehot;
          end else begin
            db_cnt <= db_cnt + 16'd1;
          end
        end
        HOLD: begin
          if (row_low) begin
            db_cnt <= '0;
          end else if (db_done) begin
            state        <= IDLE;
            bus.key_col1 <= 1'b0;
            bus.key_col2 <= 1'b0;
            bus.busy     <= 1'b0;
          end else begin
            db_cnt <= db_cnt + 16'd1;
          end
        end
        default: begin
          state        <= IDLE;
          bus.key_col1 <= 1'b0;
          bus.key_col2 <= 1'b0;
          bus.busy     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_watch_key_ctrl.sv
// Directed bench for watch_key_ctrl: keypad model, vector table for presses,
// hand sequences for bounce, tick gating and reset mid-press.
module tb_watch_key_ctrl;
  logic       clk;
  logic       reset;
  logic [5:0] keys;   // pressed keys, same bit order as inc_pulse

  watch_key_ctrl_if ifc();

  watch_key_ctrl #(
    .DEBOUNCE_CYCLES(16'd8),
    .SETTLE_CYCLES  (4'd2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // a row reads low when a pressed key sits in an actively driven column
  assign ifc.key_row2 = ~((keys[5] & ~ifc.key_col1) | (keys[4] & ~ifc.key_col2));
  assign ifc.key_row3 = ~((keys[3] & ~ifc.key_col1) | (keys[2] & ~ifc.key_col2));
  assign ifc.key_row4 = ~((keys[1] & ~ifc.key_col1) | (keys[0] & ~ifc.key_col2));

  typedef struct {
    logic       set;
    logic [5:0] keys;
    int         hold;
    logic [5:0] exp_pulse;
    int         exp_cnt;
    int         exp_lat;
  } vec_t;

  vec_t vecs [7];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_press(input logic [5:0] k, input int hold,
                           output int cnt, output int lat, output logic [5:0] val);
    cnt = 0; lat = -1; val = '0;
    keys = k;
    for (int i = 1; i <= hold; i++) begin
      step();
      if (ifc.inc_pulse != 6'd0) begin
        cnt++;
        if (lat < 0) begin lat = i; val = ifc.inc_pulse; end
      end
    end
  endtask

  task automatic run_release(output int lat, output int cnt);
    keys = '0; lat = -1; cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (ifc.inc_pulse != 6'd0) cnt++;
      if (!ifc.busy) begin lat = i; break; end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         cnt, lat, rlat, rcnt, tcnt, bcnt;
    logic [5:0] val;

    // col1 keys: S+DB+1 = 11 cycles; col2 keys: 2S+DB+1 = 13
    vecs[0] = '{1'b1, 6'b000100, 40, 6'b000100, 1, 13};  // min_l
    vecs[1] = '{1'b1, 6'b100000, 30, 6'b100000, 1, 11};  // hour_h
    vecs[2] = '{1'b1, 6'b100010, 30, 6'b100000, 1, 11};  // row2+row4 col1
    vecs[3] = '{1'b1, 6'b000001, 30, 6'b000001, 1, 13};  // sec_l
    vecs[4] = '{1'b1, 6'b001000, 30, 6'b001000, 1, 11};  // min_h
    vecs[5] = '{1'b0, 6'b010000, 30, 6'b000000, 0, 13};  // run mode: no pulse
    vecs[6] = '{1'b1, 6'b010001, 30, 6'b010000, 1, 13};  // row2+row4 col2

    ifc.set = 1'b0; ifc.tick_1hz = 1'b0; keys = '0; reset = 1'b0;
    repeat (3) step();
    chk("rst_col1", int'(ifc.key_col1), 0);
    chk("rst_col2", int'(ifc.key_col2), 0);
    chk("rst_inc", int'(ifc.inc_pulse), 0);
    chk("rst_tick", int'(ifc.tick_out), 0);
    chk("rst_busy", int'(ifc.busy), 0);
    reset = 1'b1;
    step();

    for (int t = 0; t < 3; t++) begin
      ifc.tick_1hz = 1'b1;
      step();
      ifc.tick_1hz = 1'b0;
      chk("tick_out_hi", int'(ifc.tick_out), 1);
      chk("tick_inc", int'(ifc.inc_pulse), 0);
      chk("tick_cols", int'({ifc.key_col1, ifc.key_col2}), 0);
      step();
      chk("tick_out_lo", int'(ifc.tick_out), 0);
      step();
    end

    foreach (vecs[v]) begin
      ifc.set = vecs[v].set;
      run_press(vecs[v].keys, vecs[v].hold, cnt, lat, val);
      chk($sformatf("v%0d_cnt", v), cnt, vecs[v].exp_cnt);
      if (vecs[v].exp_cnt > 0) begin
        chk($sformatf("v%0d_val", v), int'(val), int'(vecs[v].exp_pulse));
        chk($sformatf("v%0d_lat", v), lat, vecs[v].exp_lat);
      end
      run_release(rlat, rcnt);
      chk($sformatf("v%0d_rel_lat", v), rlat, 8);
      chk($sformatf("v%0d_rel_cnt", v), rcnt, 0);
      repeat (2) step();
    end

    // bounce: high for one cycle inside DEBOUNCE, then stable low
    ifc.set = 1'b1;
    keys = 6'b100000; cnt = 0; lat = -1; val = '0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (ifc.inc_pulse != 6'd0) begin
        cnt++;
        if (lat < 0) begin lat = i; val = ifc.inc_pulse; end
      end
      if (i == 4) begin
        chk("bounce_in_deb", int'(ifc.busy), 1);
        keys = '0;
      end
      if (i == 5) begin
        chk("bounce_idle", int'(ifc.busy), 0);
        keys = 6'b100000;
      end
    end
    chk("bounce_cnt", cnt, 1);
    chk("bounce_val", int'(val), int'(6'b100000));
    chk("bounce_lat", lat, 16);
    run_release(rlat, rcnt);
    chk("bounce_rel_lat", rlat, 8);
    repeat (2) step();

    // ticks while a key is held in set mode
    keys = 6'b001000; cnt = 0; lat = -1; val = '0; tcnt = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (ifc.inc_pulse != 6'd0) begin
        cnt++;
        if (lat < 0) begin lat = i; val = ifc.inc_pulse; end
      end
      if (ifc.tick_out) tcnt++;
      ifc.tick_1hz = (i == 3 || i == 10 || i == 20);
    end
    ifc.tick_1hz = 1'b0;
    chk("hold_tick_cnt", tcnt, 0);
    chk("hold_pulse_cnt", cnt, 1);
    chk("hold_pulse_val", int'(val), int'(6'b001000));
    chk("hold_pulse_lat", lat, 11);
    run_release(rlat, rcnt);
    chk("hold_rel_lat", rlat, 8);
    repeat (2) step();

    // reset while in DEBOUNCE, key kept held afterwards
    keys = 6'b100000;
    repeat (4) step();
    chk("rstd_busy_before", int'(ifc.busy), 1);
    reset = 1'b0;
    step();
    chk("rstd_col1", int'(ifc.key_col1), 0);
    chk("rstd_col2", int'(ifc.key_col2), 0);
    chk("rstd_inc", int'(ifc.inc_pulse), 0);
    chk("rstd_tick", int'(ifc.tick_out), 0);
    chk("rstd_busy", int'(ifc.busy), 0);
    reset = 1'b1;
    cnt = 0; bcnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (ifc.inc_pulse != 6'd0) cnt++;
      if (ifc.busy) bcnt++;
    end
    chk("rstd_held_pulses", cnt, 0);
    chk("rstd_held_busy", bcnt, 0);
    keys = '0;
    repeat (3) step();
    run_press(6'b100000, 30, cnt, lat, val);
    chk("rstd_fresh_cnt", cnt, 1);
    chk("rstd_fresh_val", int'(val), int'(6'b100000));
    chk("rstd_fresh_lat", lat, 11);
    run_release(rlat, rcnt);
    chk("rstd_fresh_rel", rlat, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/watch_key_ctrl.md
# watch_key_ctrl

Keypad scan, debounce and set-mode sequencer for the six-digit watch counter datapath. It drives the two keypad columns and samples three active-low rows. It converts each debounced press into exactly one single-cycle increment request for one time digit. It also gates the 1 Hz carry tick so that the counter chain either runs or accepts manual setting, never both.

## Interface
- DEBOUNCE_CYCLES, 16'd33000: number of consecutive cycles a row pattern must be stable to count as a press or a release (1 ms at 33 MHz); legal range 2–65535.
- SETTLE_CYCLES, 4'd2: cycles the block waits after changing column drive before it samples the rows; legal range 1–15.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low; clock clk.
- set  in  1  1 = manual set mode, 0 = run mode.
- tick_1hz  in  1  one-cycle pulse from the 1 s prescaler.
- key_row2, key_row3, key_row4  in  1 each  keypad rows, active-low (0 = key in the driven column is pressed).
- key_col1, key_col2  out  1 each  column drive; 0 = column active.
- inc_pulse  out  6  one-hot single-cycle increment request, bits [5:0] = {hour_h, hour_l, min_h, min_l, sec_h, sec_l}.
- tick_out  out  1  registered, gated 1 Hz tick for the seconds counter.
- busy  out  1  1 whenever the state is not IDLE.

## Operation
- Row vector: rows = {key_row2, key_row3, key_row4}. A key is pressed when rows != 3'b111.
- Key map:
  - col1: row2 → bit5, row3 → bit3, row4 → bit1.
  - col2: row2 → bit4, row3 → bit2, row4 → bit0.
- Row priority when several rows read low together: row2 > row3 > row4. Only one key is latched per press.
- Column drive by state:
  - IDLE: {col1, col2} = 00.
  - PROBE1: 01.
  - PROBE2: 10.
  - DEBOUNCE and HOLD: the latched column stays active.
- States:
  - IDLE: if rows != 111, go to PROBE1 and clear the settle counter.
  - PROBE1: wait SETTLE_CYCLES. On the sample cycle:
    - rows != 111: latch col = 1 and the priority row, then go to DEBOUNCE.
    - otherwise go to PROBE2.
  - PROBE2: same as PROBE1 with col = 2. If rows == 111, go to IDLE.
  - DEBOUNCE: the counter increments each cycle while the latched row is still low.
    - If the latched row reads high first, go to IDLE with no pulse.
    - When the count reaches DEBOUNCE_CYCLES−1, go to HOLD and emit the pulse.
  - HOLD: the counter counts consecutive cycles with the latched row high. Any low reading clears the counter. When the count reaches DEBOUNCE_CYCLES−1, go to IDLE.
  - Any unused state encoding goes to IDLE.
- inc_pulse:
  - Asserted for exactly the first cycle of HOLD, one-hot at the latched key's bit.
  - Only when set = 1 in that cycle. With set = 0 the FSM still runs but inc_pulse stays 0.
  - Holding a key produces exactly one pulse, with no auto-repeat.
- tick_out = tick_1hz & ~set, registered one cycle. set changes apply to the next tick sample.
- The block never emits an inc_pulse and a tick_out in the same cycle.

## Timing
- Reset values: state IDLE, key_col1 = 0, key_col2 = 0, inc_pulse = 0, tick_out = 0, busy = 0, all counters 0.
- Reset asserted mid-press, in any state, forces IDLE on the next edge with no pulse. The block does not resume the press after reset releases.
- All outputs are registered. key_col and busy follow the state register.
- Press latency in cycles from the first cycle the row reads low in IDLE (col1 key):
  - 1 cycle to PROBE1.
  - SETTLE_CYCLES cycles to the sample.
  - DEBOUNCE_CYCLES cycles in DEBOUNCE.
  - The pulse then appears on the next cycle.
  - A col2 key adds SETTLE_CYCLES more.
- Release latency: IDLE is reached DEBOUNCE_CYCLES cycles after the latched row goes high and stays high.
- tick_out latency: 1 cycle after tick_1hz.

## Test plan
- Reset, then set = 0, three tick_1hz pulses → tick_out pulses 1 cycle later each; inc_pulse = 0; key_col = 00.
- set = 1, DEBOUNCE_CYCLES = 8, SETTLE_CYCLES = 2, hold key_row3 low only while col2 is active (min_l) for 40 cycles, then release → exactly one inc_pulse = 6'b000100, at the computed latency; back to IDLE 8 cycles after release.
- set = 1, col1 key_row2 held with a 3-cycle bounce (low/high/low) inside DEBOUNCE → no pulse from the bounced attempt; one 6'b100000 pulse after the stable press.
- set = 1, key_row2 and key_row4 low together in col1 → single pulse 6'b100000 only.
- set = 1, tick_1hz pulses during a held key → tick_out stays 0; only the key pulse is seen.
- Reset asserted while in DEBOUNCE → IDLE, outputs at reset values next cycle, no pulse after reset is released while the key is still held until a fresh release and press.
